// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic-unit command path: ALU function codes,
// issuer FSM state encoding and a small decode helper.
package arith_pkg;

    // Function codes understood by the arithmetic unit
    localparam logic [1:0] FUN_ADD = 2'b00;
    localparam logic [1:0] FUN_SUB = 2'b01;
    localparam logic [1:0] FUN_MUL = 2'b10;
    localparam logic [1:0] FUN_DIV = 2'b11;

    // Issuer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } issuer_state_e;

    // A divide with a zero divisor never reaches the arithmetic unit
    function automatic logic is_div_by_zero(input logic [1:0] fun, input logic b_is_zero);
        return (fun == FUN_DIV) && b_is_zero;
    endfunction

endpackage

// File: rtl/arith_cmd_issuer.sv
// Initiator for the arithmetic unit. Takes one ALU command at a time over a
// valid/ready port, drives a single-cycle enable with registered operands,
// waits out the unit's result latency, and hands the captured result back
// over a valid/ready response port. Divide-by-zero is answered locally.
module arith_cmd_issuer
    import arith_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 16,
    parameter int LAT       = 1
) (
    input  logic                 clk,
    input  logic                 RST,

    // command port
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [IN_WIDTH-1:0]  cmd_a,
    input  logic [IN_WIDTH-1:0]  cmd_b,
    input  logic [1:0]           cmd_fun,

    // response port
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OUT_WIDTH-1:0] rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_err,

    // arithmetic unit side
    output logic [IN_WIDTH-1:0]  A,
    output logic [IN_WIDTH-1:0]  B,
    output logic [1:0]           ALU_FUN,
    output logic                 Arith_Enable,
    input  logic [OUT_WIDTH-1:0] Arith_OUT,
    input  logic                 Carry_OUT,
    input  logic                 Arith_Flag
);

    // Wait counter spans 0..LAT-1; sized for LAT+1 values so LAT=1 still gets one bit
    localparam int              CNT_W    = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    issuer_state_e          state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [IN_WIDTH-1:0]    a_nxt, b_nxt;
    logic [1:0]             fun_nxt;
    logic                   enable_nxt;
    logic                   rsp_valid_nxt;
    logic [OUT_WIDTH-1:0]   rsp_result_nxt;
    logic                   rsp_carry_nxt;
    logic                   rsp_err_nxt;
    logic                   accept;
    logic                   div_zero;

    // Ready when idle, or when the held response is being popped this edge.
    // Held low while reset is asserted so every output reads 0 during reset.
    assign cmd_ready = ~RST & ((state == IDLE) | ((state == RESP) & rsp_ready));
    assign accept    = cmd_valid & cmd_ready;
    assign div_zero  = is_div_by_zero(cmd_fun, (cmd_b == '0));

    // Next-state and next-register-value decode
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        a_nxt          = A;
        b_nxt          = B;
        fun_nxt        = ALU_FUN;
        enable_nxt     = 1'b0;
        rsp_valid_nxt  = rsp_valid;
        rsp_result_nxt = rsp_result;
        rsp_carry_nxt  = rsp_carry;
        rsp_err_nxt    = rsp_err;

        case (state)
            IDLE: begin
                // only an accept (handled below) leaves IDLE
            end
            ISSUE: begin
                cnt_nxt   = CNT_INIT;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    rsp_result_nxt = Arith_OUT;
                    rsp_carry_nxt  = Carry_OUT;
                    rsp_err_nxt    = ~Arith_Flag;
                    rsp_valid_nxt  = 1'b1;
                    a_nxt          = '0;
                    b_nxt          = '0;
                    fun_nxt        = '0;
                    state_nxt      = RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Accept is only possible in IDLE or on the RESP pop edge, so it
        // overrides whatever the state decode above chose.
        if (accept) begin
            if (div_zero) begin
                rsp_result_nxt = '1;
                rsp_carry_nxt  = 1'b1;
                rsp_err_nxt    = 1'b1;
                rsp_valid_nxt  = 1'b1;
                a_nxt          = '0;
                b_nxt          = '0;
                fun_nxt        = '0;
                state_nxt      = RESP;
            end else begin
                a_nxt         = cmd_a;
                b_nxt         = cmd_b;
                fun_nxt       = cmd_fun;
                enable_nxt    = 1'b1;
                rsp_valid_nxt = 1'b0;
                state_nxt     = ISSUE;
            end
        end
    end

    // FSM, wait counter, ALU drive and response registers
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            cnt          <= '0;
            A            <= '0;
            B            <= '0;
            ALU_FUN      <= '0;
            Arith_Enable <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            A            <= a_nxt;
            B            <= b_nxt;
            ALU_FUN      <= fun_nxt;
            Arith_Enable <= enable_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_result   <= rsp_result_nxt;
            rsp_carry    <= rsp_carry_nxt;
            rsp_err      <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_arith_cmd_issuer.sv
// Bench for arith_cmd_issuer: a stand-in arithmetic unit with one-cycle
// registered latency, directed scenarios followed by random traffic, and a
// queue-based scoreboard fed from accepted commands.
module tb_arith_cmd_issuer;
    import arith_pkg::*;

    localparam int IW  = 8;
    localparam int OW  = 16;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          RST = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [IW-1:0] cmd_a = '0;
    logic [IW-1:0] cmd_b = '0;
    logic [1:0]    cmd_fun = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [OW-1:0] rsp_result;
    logic          rsp_carry;
    logic          rsp_err;
    logic [IW-1:0] A, B;
    logic [1:0]    ALU_FUN;
    logic          Arith_Enable;
    logic [OW-1:0] Arith_OUT;
    logic          Carry_OUT;
    logic          Arith_Flag;

    always #5 clk = ~clk;

    arith_cmd_issuer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LAT(LAT)) dut (
        .clk(clk), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .Arith_Enable(Arith_Enable),
        .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Arith_Flag(Arith_Flag)
    );

    // ---------------- stand-in arithmetic unit (active-low reset) ----------
    logic          alu_rst_n;
    logic          force_flag0 = 1'b0;
    logic [OW-1:0] alu_out;
    logic          alu_carry, alu_flag;
    assign alu_rst_n = ~RST;

    always @(posedge clk or negedge alu_rst_n) begin
        if (!alu_rst_n) begin
            alu_out   <= '0;
            alu_carry <= 1'b0;
            alu_flag  <= 1'b0;
        end else begin
            alu_flag <= Arith_Enable;
            if (Arith_Enable) begin
                case (ALU_FUN)
                    2'b00:   begin alu_out <= 16'(A) + 16'(B); alu_carry <= 1'b0; end
                    2'b01:   begin alu_out <= 16'(A) - 16'(B); alu_carry <= (A < B); end
                    2'b10:   begin alu_out <= 16'(A) * 16'(B); alu_carry <= 1'b0; end
                    default: begin alu_out <= (B != 0) ? 16'(A) / 16'(B) : '1; alu_carry <= 1'b0; end
                endcase
            end
        end
    end
    assign Arith_OUT  = alu_out;
    assign Carry_OUT  = alu_carry;
    assign Arith_Flag = alu_flag & ~force_flag0;

    // ---------------- reference model and bookkeeping ----------------------
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int en_pulses = 0;
    int n_sent = 0;
    int n_rsp = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;
    bit rr_random = 1'b0;

    // Expected {result, carry, err} from the command alone
    function automatic logic [17:0] model(input logic [1:0] f, input int a, input int b, input bit ff);
        int r;
        bit c;
        c = 1'b0;
        case (f)
            2'b00: r = a + b;
            2'b01: begin r = a - b; c = (a < b); end
            2'b10: r = a * b;
            default: begin
                if (b == 0) return {16'hFFFF, 1'b1, 1'b1};
                r = a / b;
            end
        endcase
        return {r[15:0], c, ff};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;
    always @(negedge clk) if (Arith_Enable) en_pulses++;

    // Scoreboard: push on handshake of a command, pop on handshake of a response
    always @(negedge clk) begin
        if (!RST) begin
            if (cmd_valid && cmd_ready)
                exp_q.push_back(model(cmd_fun, int'(cmd_a), int'(cmd_b), force_flag0));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_rsp++;
                    check("rsp", 64'({rsp_result, rsp_carry, rsp_err}), 64'(mon_e));
                end
            end
        end
    end

    // Random response back-pressure
    always @(posedge clk) begin
        if (rr_random) begin
            #1 rsp_ready = (($urandom % 4) != 0);
        end
    end

    // Present a command and hold it until accepted; returns just after the accept edge
    task automatic send(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
        int n;
        cmd_fun = f; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n_sent++;
    endtask

    // Wait (on negedges) for rsp_valid; returns the cycle count where it was seen
    task automatic wait_rsp(output int at_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check("rsp_timeout", 64'(rsp_valid), 64'd1);
        at_cyc = cyc;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, t, e0, n;
        logic [17:0] snap;
        logic [1:0]  rf;
        logic [7:0]  ra, rb;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_enable", 64'(Arith_Enable), 64'd0);
        check("rst_outs", 64'({A, B, ALU_FUN, rsp_result, rsp_carry, rsp_err}), 64'd0);
        RST = 1'b0;
        #1 check("rel_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;

        // ADD: latency and single enable pulse
        rsp_ready = 1'b1;
        e0 = en_pulses;
        send(FUN_ADD, 8'hF0, 8'h20);
        k = cyc;
        wait_rsp(t);
        check("add_latency", 64'(t - k), 64'd2);
        check("add_enable_pulses", 64'(en_pulses - e0), 64'd1);
        check("add_direct", 64'({rsp_result, rsp_carry, rsp_err}), 64'({16'h0110, 1'b0, 1'b0}));
        check("resp_ops_cleared", 64'({A, B, ALU_FUN}), 64'd0);
        @(posedge clk); #1;

        // MUL
        send(FUN_MUL, 8'hFF, 8'hFF);
        wait_rsp(t);
        check("mul_direct", 64'({rsp_result, rsp_err}), 64'({16'hFE01, 1'b0}));
        @(posedge clk); #1;

        // DIV by zero: local trap, no enable
        e0 = en_pulses;
        send(FUN_DIV, 8'h10, 8'h00);
        k = cyc;
        wait_rsp(t);
        check("div0_latency", 64'(t - k), 64'd0);
        check("div0_no_enable", 64'(en_pulses - e0), 64'd0);
        check("div0_direct", 64'({rsp_result, rsp_carry, rsp_err}), 64'({16'hFFFF, 1'b1, 1'b1}));
        @(posedge clk); #1;

        // Response stall, then pop and accept on the same edge
        rsp_ready = 1'b0;
        send(FUN_ADD, 8'h12, 8'h34);
        wait_rsp(t);
        snap = {rsp_result, rsp_carry, rsp_err};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", 64'({rsp_valid, rsp_result, rsp_carry, rsp_err}), 64'({1'b1, snap}));
            check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        #1 check("pop_cmd_ready", 64'(cmd_ready), 64'd1);
        send(FUN_SUB, 8'h05, 8'h03);
        check("pop_accept_state", 64'({rsp_valid, Arith_Enable}), 64'({1'b0, 1'b1}));
        wait_rsp(t);
        check("sub_direct", 64'({rsp_result, rsp_carry, rsp_err}), 64'({16'h0002, 1'b0, 1'b0}));
        @(posedge clk); #1;

        // Missing Arith_Flag
        force_flag0 = 1'b1;
        send(FUN_ADD, 8'h33, 8'h44);
        wait_rsp(t);
        check("noflag_direct", 64'({rsp_result, rsp_err}), 64'({16'h0077, 1'b1}));
        @(posedge clk); #1;
        force_flag0 = 1'b0;

        // Reset during WAIT
        send(FUN_ADD, 8'h01, 8'h02);
        @(posedge clk); #1;
        RST = 1'b1;
        exp_q.delete();
        n_sent--;
        #1 check("rst_wait_outputs",
                 64'({cmd_ready, rsp_valid, Arith_Enable, A, B, ALU_FUN, rsp_result, rsp_carry, rsp_err}),
                 64'd0);
        @(negedge clk);
        RST = 1'b0;
        #1 check("rst_wait_release_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        send(FUN_ADD, 8'h7F, 8'h81);
        wait_rsp(t);
        check("post_rst_add", 64'({rsp_result, rsp_carry, rsp_err}), 64'({16'h0100, 1'b0, 1'b0}));
        @(posedge clk); #1;

        // Random traffic with random back-pressure
        rr_random = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rf = 2'($urandom_range(0, 3));
            ra = 8'($urandom);
            rb = (($urandom % 5) == 0) ? 8'h00 : 8'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send(rf, ra, rb);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        rr_random = 1'b0;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("rsp_count", 64'(n_rsp), 64'(n_sent));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
